// File: rtl/cpu_ram_port_arbiter.sv
// cpu_ram_port_arbiter
// Shares the single read/write port of the 32-bit CPU RAM between the CPU bus
// and the flash DMA write stream (vdp_clk domain). Every RAM command is
// registered, and a CPU access completes with cpu_ready two cycles after its grant.
// Optional feature: define CPU_RAM_ARBITER_FAIRNESS_EN to cap consecutive DMA
// grants at MAX_DMA_BURST while the CPU waits. Without it, DMA has strict priority.
module cpu_ram_port_arbiter #(
  parameter int ADDR_BITS     = 15,
  parameter int MAX_DMA_BURST = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic [ADDR_BITS-1:0] cpu_address,
  input  logic [3:0]           cpu_wstrb,
  input  logic [31:0]          cpu_write_data,
  output logic                 cpu_ready,
  output logic [31:0]          cpu_read_data,
  input  logic                 dma_req,
  input  logic [ADDR_BITS-1:0] dma_address,
  input  logic [3:0]           dma_wstrb,
  input  logic [31:0]          dma_write_data,
  output logic                 dma_ack,
  output logic                 ram_cs,
  output logic [ADDR_BITS-1:0] ram_address,
  output logic [3:0]           ram_wstrb,
  output logic [31:0]          ram_write_data,
  input  logic [31:0]          ram_read_data
);

  // state | meaning
  // IDLE  | no CPU access outstanding, CPU may be granted
  // CMD   | CPU command is on the RAM port
  // RESP  | RAM returns data for the CPU command, cpu_ready pulses
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } cpu_state_t;

  cpu_state_t state, state_nxt;
  logic       cpu_busy;
  logic       cpu_eligible;
  logic       cpu_win;
  logic       dma_win;

  // CPU access tracker state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // CPU access tracker next state: a grant walks the access through CMD and RESP
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cpu_win) state_nxt = ST_CMD;
      ST_CMD:  state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // CPU-side outputs decoded from the tracker state; busy covers the ready cycle too
  always_comb begin
    cpu_busy      = (state != ST_IDLE);
    cpu_ready     = (state == ST_RESP);
    cpu_read_data = cpu_ready ? ram_read_data : 32'h0;
  end

  // No grants are made while reset is asserted, so the DMA source never
  // advances on a command that reset would throw away.
  assign cpu_eligible = cpu_req && !cpu_busy && !reset;

`ifdef CPU_RAM_ARBITER_FAIRNESS_EN
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_DMA_BURST);

  logic [7:0] burst_cnt;

  assign cpu_win = cpu_eligible && (!dma_req || (burst_cnt == BURST_LIMIT));

  // Count DMA grants made while the CPU waits; any CPU grant or idle CPU restarts the run
  always_ff @(posedge clk) begin
    if (reset || cpu_win || !cpu_eligible) begin
      burst_cnt <= 8'd0;
    end else if (dma_win && (burst_cnt != BURST_LIMIT)) begin
      burst_cnt <= burst_cnt + 8'd1;
    end
  end
`else
  // The burst limit only matters with fairness built in.
  logic unused_max_dma_burst;
  assign unused_max_dma_burst = ^8'(MAX_DMA_BURST);

  assign cpu_win = cpu_eligible && !dma_req;
`endif

  assign dma_win = dma_req && !cpu_win && !reset;
  assign dma_ack = dma_win;

  // RAM command register: load the slot winner, otherwise idle the port and hold address/data
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_cs         <= 1'b0;
      ram_address    <= '0;
      ram_wstrb      <= 4'h0;
      ram_write_data <= 32'h0;
    end else if (cpu_win) begin
      ram_cs         <= 1'b1;
      ram_address    <= cpu_address;
      ram_wstrb      <= cpu_wstrb;
      ram_write_data <= cpu_write_data;
    end else if (dma_win) begin
      ram_cs         <= 1'b1;
      ram_address    <= dma_address;
      ram_wstrb      <= dma_wstrb;
      ram_write_data <= dma_write_data;
    end else begin
      ram_cs         <= 1'b0;
      ram_wstrb      <= 4'h0;
    end
  end

endmodule

// File: tb/tb_cpu_ram_port_arbiter.sv
// tb_cpu_ram_port_arbiter
// Directed stimulus with literal expectations, plus a cycle-by-cycle reference
// model of the arbitration rules (grant history and DMA run length) checked
// against every DUT output. Honours CPU_RAM_ARBITER_FAIRNESS_EN like the design.
module tb_cpu_ram_port_arbiter;

  localparam int AW = 15;
  localparam int MAX_BURST = 8;
`ifdef CPU_RAM_ARBITER_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_address = '0;
  logic [3:0]    cpu_wstrb = 4'h0;
  logic [31:0]   cpu_write_data = 32'h0;
  logic          cpu_ready;
  logic [31:0]   cpu_read_data;
  logic          dma_req = 1'b0;
  logic [AW-1:0] dma_address = '0;
  logic [3:0]    dma_wstrb = 4'h0;
  logic [31:0]   dma_write_data = 32'h0;
  logic          dma_ack;
  logic          ram_cs;
  logic [AW-1:0] ram_address;
  logic [3:0]    ram_wstrb;
  logic [31:0]   ram_write_data;
  logic [31:0]   ram_read_data = 32'h0;

  int total = 0;
  int bad = 0;

  cpu_ram_port_arbiter #(.ADDR_BITS(AW), .MAX_DMA_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_wstrb(cpu_wstrb),
    .cpu_write_data(cpu_write_data), .cpu_ready(cpu_ready), .cpu_read_data(cpu_read_data),
    .dma_req(dma_req), .dma_address(dma_address), .dma_wstrb(dma_wstrb),
    .dma_write_data(dma_write_data), .dma_ack(dma_ack),
    .ram_cs(ram_cs), .ram_address(ram_address), .ram_wstrb(ram_wstrb),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
  );

  always #5 clk = ~clk;

  // Simple RAM behind the port: read data one cycle after a read command
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[10'h012] <= 32'hDEADBEEF;
      mem[10'h020] <= 32'h5555AAAA;
    end else if (ram_cs) begin
      if (ram_wstrb == 4'h0) begin
        ram_read_data <= mem[ram_address[9:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (ram_wstrb[b]) mem[ram_address[9:0]][b*8 +: 8] <= ram_write_data[b*8 +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-slot decision from the arbitration rules
  bit            model_ok = 1'b0;
  bit            g1 = 1'b0;      // CPU granted one slot ago
  bit            g2 = 1'b0;      // CPU granted two slots ago
  int            run = 0;        // DMA grants in a row while the CPU waited
  bit            e_cs = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [3:0]    e_wstrb = 4'h0;
  logic [31:0]   e_data = 32'h0;

  task automatic model_step();
    bit elig, cwin, dwin;
    if (model_ok) begin
      check("m_ram_cs", 32'(ram_cs), 32'(e_cs));
      check("m_ram_address", 32'(ram_address), 32'(e_addr));
      check("m_ram_wstrb", 32'(ram_wstrb), 32'(e_wstrb));
      check("m_ram_write_data", ram_write_data, e_data);
      check("m_cpu_ready", 32'(cpu_ready), 32'(g2));
      check("m_cpu_read_data", cpu_read_data, g2 ? ram_read_data : 32'h0);
    end
    elig = cpu_req && !(g1 || g2) && !reset;
    cwin = elig && (!dma_req || (FAIR && run >= MAX_BURST));
    dwin = dma_req && !cwin && !reset;
    if (model_ok) check("m_dma_ack", 32'(dma_ack), 32'(dwin));
    if (reset) begin
      e_cs = 1'b0; e_addr = '0; e_wstrb = 4'h0; e_data = 32'h0;
      g1 = 1'b0; g2 = 1'b0; run = 0; model_ok = 1'b1;
    end else begin
      g2 = g1;
      g1 = cwin;
      if (cwin) begin
        e_cs = 1'b1; e_addr = cpu_address; e_wstrb = cpu_wstrb; e_data = cpu_write_data;
      end else if (dwin) begin
        e_cs = 1'b1; e_addr = dma_address; e_wstrb = dma_wstrb; e_data = dma_write_data;
      end else begin
        e_cs = 1'b0; e_wstrb = 4'h0;
      end
      if (cwin || !elig) run = 0;
      else if (dwin) run++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dma(input logic req, input logic [AW-1:0] a);
    dma_req = req;
    dma_address = a;
    dma_wstrb = 4'hF;
    dma_write_data = 32'hD000_0000 | 32'(a);
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic [31:0] exp);
    cpu_req = 1'b1; cpu_address = a; cpu_wstrb = 4'h0; cpu_write_data = 32'h0;
    @(negedge clk); check("rd_grant_ack", 32'(dma_ack), 32'h0); tick();
    @(negedge clk);
    check("rd_t1_cs", 32'(ram_cs), 32'h1);
    check("rd_t1_addr", 32'(ram_address), 32'(a));
    check("rd_t1_wstrb", 32'(ram_wstrb), 32'h0);
    tick();
    @(negedge clk);
    check("rd_t2_ready", 32'(cpu_ready), 32'h1);
    check("rd_t2_data", cpu_read_data, exp);
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    check("rd_t3_no_regrant", 32'(ram_cs), 32'h0);
    check("rd_t3_ready_low", 32'(cpu_ready), 32'h0);
    tick();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ram_cs", 32'(ram_cs), 32'h0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'h0);
    check("rst_ram_addr", 32'(ram_address), 32'h0);
    check("rst_ram_data", ram_write_data, 32'h0);
    tick();

    // Lone CPU read
    cpu_read(15'h0012, 32'hDEADBEEF);

    // DMA burst of four back-to-back writes
    for (int i = 0; i < 4; i++) begin
      drive_dma(1'b1, 15'(15'h100 + i));
      @(negedge clk);
      check("burst_ack", 32'(dma_ack), 32'h1);
      if (i > 0) check("burst_addr", 32'(ram_address), 32'(15'h100 + i - 1));
      tick();
    end
    dma_req = 1'b0;
    @(negedge clk);
    check("burst_last_cs", 32'(ram_cs), 32'h1);
    check("burst_last_addr", 32'(ram_address), 32'h103);
    check("burst_last_data", ram_write_data, 32'hD000_0103);
    tick();

    // Contention: CPU read of 0x20 against a continuous DMA stream
    cpu_req = 1'b1; cpu_address = 15'h020; cpu_wstrb = 4'h0;
    for (int i = 0; i < (FAIR ? MAX_BURST : 12); i++) begin
      drive_dma(1'b1, 15'(15'h200 + i));
      @(negedge clk);
      check("cont_dma_ack", 32'(dma_ack), 32'h1);
      tick();
    end
`ifdef CPU_RAM_ARBITER_FAIRNESS_EN
    drive_dma(1'b1, 15'h208);
`else
    dma_req = 1'b0;
`endif
    @(negedge clk);
    check("cont_cpu_slot_ack", 32'(dma_ack), 32'h0);
    tick();
    @(negedge clk);
    check("cont_cpu_cs", 32'(ram_cs), 32'h1);
    check("cont_cpu_addr", 32'(ram_address), 32'h020);
`ifdef CPU_RAM_ARBITER_FAIRNESS_EN
    check("cont_dma_resume", 32'(dma_ack), 32'h1);
`endif
    tick();
    dma_req = 1'b0;
    @(negedge clk);
    check("cont_ready", 32'(cpu_ready), 32'h1);
    check("cont_data", cpu_read_data, 32'h5555AAAA);
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    check("cont_ready_low", 32'(cpu_ready), 32'h0);
    tick();

    // CPU write with DMA arriving one cycle later
    cpu_req = 1'b1; cpu_address = 15'h030; cpu_wstrb = 4'h3; cpu_write_data = 32'hAABBCCDD;
    @(negedge clk); check("wr_ack_low", 32'(dma_ack), 32'h0); tick();
    drive_dma(1'b1, 15'h031);
    @(negedge clk);
    check("wr_t1_addr", 32'(ram_address), 32'h030);
    check("wr_t1_wstrb", 32'(ram_wstrb), 32'h3);
    check("wr_t1_data", ram_write_data, 32'hAABBCCDD);
    check("wr_t1_dma_ack", 32'(dma_ack), 32'h1);
    tick();
    dma_req = 1'b0;
    @(negedge clk);
    check("wr_t2_dma_addr", 32'(ram_address), 32'h031);
    check("wr_t2_dma_data", ram_write_data, 32'hD000_0031);
    check("wr_t2_ready", 32'(cpu_ready), 32'h1);
    tick();
    cpu_req = 1'b0;
    tick();
    cpu_read(15'h0030, 32'h0000CCDD);

    // Reset in the cycle after a CPU read grant
    cpu_req = 1'b1; cpu_address = 15'h012; cpu_wstrb = 4'h0;
    tick();
    reset = 1'b1;
    @(negedge clk); check("rm_t1_cs", 32'(ram_cs), 32'h1); tick();
    reset = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("rm_t2_no_ready", 32'(cpu_ready), 32'h0);
    check("rm_t2_cs_low", 32'(ram_cs), 32'h0);
    tick();
    @(negedge clk); check("rm_t3_no_ready", 32'(cpu_ready), 32'h0); tick();
    cpu_read(15'h0012, 32'hDEADBEEF);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
